serial_parity_rx: RTL and testbench



---
 rtl/serial_parity_rx.sv | 102 ++++++++++
 tb/tb_serial_parity_rx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start/data/parity/stop frames are strobed in by bit_en.
// Each completed frame is reported with a one-cycle valid pulse and its parity/framing flags.
module serial_parity_rx #(
  parameter int   DATA_W     = 8,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            shift_d = '0;
            cnt_d   = '0;
            acc_d   = 1'b0;
            state_d = DATA;
          end
        end
        DATA: begin
          // LSB first: new bits enter at the top and walk down.
          shift_d           = shift_q >> 1;
          shift_d[DATA_W-1] = rx;
          acc_d             = acc_q ^ rx;
          cnt_d             = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          acc_d   = acc_q ^ rx;
          state_d = STOP;
        end
        STOP: begin
          data_d  = shift_q;
          perr_d  = acc_q ^ PARITY_ODD;
          ferr_d  = ~rx;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: table of frames plus reset-abort and back-to-back sequences.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int checks = 0;
  int passes = 0;
  int vcnt_e = 0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_e), .valid(valid_e), .parity_err(perr_e),
    .frame_err(ferr_e), .busy(busy_e)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
    .data_out(data_o), .valid(valid_o), .parity_err(perr_o),
    .frame_err(ferr_o), .busy(busy_o)
  );

  always @(posedge clk) if (valid_e) vcnt_e++;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       odd;
    int         gap;   // idle cycles between strobes; -1 = random 2..6
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic strobe(input logic b, input int idle);
    repeat (idle) begin
      rx = ~rx;
      @(posedge clk); #1;
    end
    bit_en = 1'b1;
    rx     = b;
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(6, 2)) : g;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic odd, input int gap,
                            input logic [7:0] xd, input logic xp, input logic xf);
    strobe(1'b0, pick_gap(gap));
    chk("busy_after_start", odd ? busy_o : busy_e, 1);
    chk("valid_low_in_frame", odd ? valid_o : valid_e, 0);
    for (int i = 0; i < 8; i++) strobe(d[i], pick_gap(gap));
    strobe(par, pick_gap(gap));
    strobe(stop, pick_gap(gap));
    chk("valid_after_stop", odd ? valid_o : valid_e, 1);
    chk("busy_after_stop",  odd ? busy_o  : busy_e,  0);
    chk("data_out",   odd ? data_o : data_e, xd);
    chk("parity_err", odd ? perr_o : perr_e, xp);
    chk("frame_err",  odd ? ferr_o : ferr_e, xf);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0,  0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0,  2, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0,  0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0,  0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1,  1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1,  0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h96, 1'b0, 1'b1, 1'b0, -1, 8'h96, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  busy_e,  0);
    chk("rst_valid", valid_e, 0);
    chk("rst_data",  data_e,  0);
    chk("rst_perr",  perr_e,  0);
    chk("rst_ferr",  ferr_e,  0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Idle strobes with the line high must not start a frame.
    strobe(1'b1, 0);
    strobe(1'b1, 1);
    chk("idle_no_busy", busy_e, 0);

    for (int v = 0; v < 7; v++)
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].odd, vecs[v].gap,
                 vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
    rx = 1'b1;
    @(posedge clk); #1;
    chk("valid_single_pulse", valid_e, 0);
    chk("frames_seen_table", vcnt_e, 7);

    // Abandon a frame with reset after 4 data strobes.
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(i[0], 0);
    chk("busy_before_abort", busy_e, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  busy_e,  0);
    chk("abort_valid", valid_e, 0);
    chk("abort_data",  data_e,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_frame", vcnt_e, 7);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0, 8'h5A, 1'b0, 1'b0);

    // Back-to-back: the next start bit is strobed in the valid cycle.
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 0, 8'hFF, 1'b0, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 1'b0, 0, 8'h80, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("frames_seen_total", vcnt_e, 10);
    chk("final_idle", busy_e, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
